bit_balance_seq: RTL and testbench

- Sequenced bit-balance engine: accepts an N-bit word over a valid/ready handshake and scans it serially, BPC bits per cycle.
- Accumulates counts of ones and zeros, then presents ones, zeros, |ones−zeros| and majority flags on an output valid/ready handshake.
- Sits between a word producer and any consumer needing ones/zeros balance. It is the controller that time-shares one narrow counting slice across the whole word.

---
 rtl/bit_balance_pkg.sv | 39 +++
 rtl/popcount_slice.sv | 28 ++
 rtl/bit_balance_seq.sv | 189 ++++++++++++++++++
 tb/tb_bit_balance_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_balance_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_balance_pkg
// Description : Shared types and helpers for the bit-balance engine: the
//               controller state set, the legal per-cycle slice widths and
//               the count-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_balance_pkg;

  // Controller states. The two-bit encoding leaves one unused code, which
  // the controller treats as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice widths the counting datapath supports.
  localparam int unsigned NUM_LEGAL_BPC = 4;
  localparam int unsigned LEGAL_BPC [NUM_LEGAL_BPC] = '{1, 2, 4, 8};

  // Width needed to hold any count from 0 up to and including n.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // True when bpc is a supported slice width and divides the word evenly.
  function automatic bit bpc_is_legal(input int bpc, input int n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NUM_LEGAL_BPC); i++) begin
      if (bpc == int'(LEGAL_BPC[i])) hit = 1'b1;
    end
    return hit && (n > 0) && ((n % bpc) == 0);
  endfunction

endpackage : bit_balance_pkg
`default_nettype wire

// File: rtl/popcount_slice.sv
`default_nettype none
// ============================================================================
// Module      : popcount_slice
// Description : Combinational population count of a W-bit slice. Used as the
//               single counting slice that the scan controller time-shares
//               across the whole input word.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_slice
  import bit_balance_pkg::*;
#(
  parameter  int W  = 1,
  localparam int PW = cw_of(W)
) (
  input  logic [W-1:0]  bits_i,
  output logic [PW-1:0] count_o
);

  // Sum the slice bits one at a time; W is small so a ripple sum is fine.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end

endmodule : popcount_slice
`default_nettype wire

// File: rtl/bit_balance_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_balance_seq
// Description : Sequenced bit-balance engine. Accepts an N-bit word over a
//               valid/ready handshake, scans it BPC bits per cycle through a
//               single popcount slice, then presents ones, zeros, |ones-zeros|
//               and majority flags on an output valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_balance_seq
  import bit_balance_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int BPC = 1,
  localparam int CW  = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_ones,
  output logic [CW-1:0] out_zeros,
  output logic [CW-1:0] out_diff,
  output logic          out_more_ones,
  output logic          out_balanced,
  output logic          out_valid,
  input  logic          out_ready
);

  // Number of scan cycles per word, width of the scan counter and width of
  // a single slice popcount.
  localparam int SCANS = N / BPC;
  localparam int SW    = cw_of(SCANS);
  localparam int PW    = cw_of(BPC);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] ones_q,  ones_d;
  logic [CW-1:0] zeros_q, zeros_d;
  logic [SW-1:0] cnt_q,   cnt_d;

  // Result registers; they only change on the edge that enters DONE.
  logic [CW-1:0] res_ones_q;
  logic [CW-1:0] res_zeros_q;
  logic [CW-1:0] res_diff_q;
  logic          res_more_q;
  logic          res_bal_q;
  logic          res_load;

  // --------------------------------------------------------------------------
  // Counting datapath
  // --------------------------------------------------------------------------
  logic [PW-1:0] slice_pop;
  logic [CW-1:0] ones_nx;
  logic [CW-1:0] zeros_nx;
  logic [CW-1:0] diff_nx;
  logic          more_nx;
  logic          bal_nx;

  // The one shared slice always looks at the low BPC bits of the shifter.
  popcount_slice #(
    .W (BPC)
  ) u_popcount_slice (
    .bits_i  (shift_q[BPC-1:0]),
    .count_o (slice_pop)
  );

  // Running totals including the current slice, plus the balance results
  // derived from them. These are what the final scan edge captures.
  always_comb begin
    ones_nx  = ones_q + CW'(slice_pop);
    zeros_nx = zeros_q + (CW'(BPC) - CW'(slice_pop));
    if (ones_nx >= zeros_nx) begin
      diff_nx = ones_nx - zeros_nx;
    end else begin
      diff_nx = zeros_nx - ones_nx;
    end
    more_nx = (ones_nx > zeros_nx);
    bal_nx  = (ones_nx == zeros_nx);
  end

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  // Next-state logic: flush overrides both the accept in IDLE and the
  // output handshake in DONE.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    ones_d   = ones_q;
    zeros_d  = zeros_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_d = in_data;
            ones_d  = '0;
            zeros_d = '0;
            cnt_d   = SW'(SCANS);
            state_d = SCAN;
          end
        end

        SCAN: begin
          ones_d  = ones_nx;
          zeros_d = zeros_nx;
          shift_d = shift_q >> BPC;
          cnt_d   = cnt_q - SW'(1);
          // Last slice: capture results and present them next cycle.
          if (cnt_q == SW'(1)) begin
            state_d  = DONE;
            res_load = 1'b1;
          end
        end

        DONE: begin
          // No accept here even with out_ready high; IDLE must come first.
          if (out_ready) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controller and scan datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      ones_q  <= '0;
      zeros_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers, loaded only on the DONE entry edge so they stay
  // stable under output backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ones_q  <= '0;
      res_zeros_q <= '0;
      res_diff_q  <= '0;
      res_more_q  <= 1'b0;
      res_bal_q   <= 1'b0;
    end else if (res_load) begin
      res_ones_q  <= ones_nx;
      res_zeros_q <= zeros_nx;
      res_diff_q  <= diff_nx;
      res_more_q  <= more_nx;
      res_bal_q   <= bal_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_ones      = res_ones_q;
  assign out_zeros     = res_zeros_q;
  assign out_diff      = res_diff_q;
  assign out_more_ones = res_more_q;
  assign out_balanced  = res_bal_q;

endmodule : bit_balance_seq
`default_nettype wire

// File: tb/tb_bit_balance_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_balance_seq
// Description : Self-checking bench for bit_balance_seq. Directed table of
//               words, hand sequences for timing/flush/reset corners, a
//               BPC=2 instance, and a randomized phase scored against a
//               bit-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_balance_seq;

  localparam int N  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // BPC = 1 instance
  logic          flush, in_valid, out_ready;
  logic [N-1:0]  in_data;
  logic          in_ready, out_valid, out_more_ones, out_balanced;
  logic [CW-1:0] out_ones, out_zeros, out_diff;

  bit_balance_seq #(.N(N), .BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_ones(out_ones), .out_zeros(out_zeros), .out_diff(out_diff),
    .out_more_ones(out_more_ones), .out_balanced(out_balanced),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // BPC = 2 instance
  logic          flush2, in_valid2, out_ready2;
  logic [N-1:0]  in_data2;
  logic          in_ready2, out_valid2, out_more_ones2, out_balanced2;
  logic [CW-1:0] out_ones2, out_zeros2, out_diff2;

  bit_balance_seq #(.N(N), .BPC(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_ones(out_ones2), .out_zeros(out_zeros2), .out_diff(out_diff2),
    .out_more_ones(out_more_ones2), .out_balanced(out_balanced2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: count the bits and derive the balance figures.
  typedef struct {
    int ones; int zeros; int diff; int more; int bal;
  } res_t;

  function automatic res_t ref_model(input logic [N-1:0] d);
    res_t r;
    r.ones = 0;
    for (int i = 0; i < N; i++) if (d[i]) r.ones++;
    r.zeros = N - r.ones;
    r.diff  = (r.ones > r.zeros) ? r.ones - r.zeros : r.zeros - r.ones;
    r.more  = (r.ones > r.zeros) ? 1 : 0;
    r.bal   = (r.ones == r.zeros) ? 1 : 0;
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] data;
    res_t         exp;
    int           hold;
  } vec_t;

  // Cycle counter and accept recorder (BPC = 1 instance).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int acc_cyc[$];
  always @(negedge clk)
    if (!rst && in_valid && in_ready && !flush) acc_cyc.push_back(cyc);

  // Scoreboard used during the randomized phase.
  bit           mon_en = 1'b0;
  logic [N-1:0] exp_q[$];
  int           n_hs = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("sb_flags_exclusive", {31'd0, out_more_ones & out_balanced & out_valid}, 0);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_hs++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_result", 1, 0);
          end else begin
            logic [N-1:0] d;
            res_t r;
            d = exp_q.pop_front();
            r = ref_model(d);
            check("sb_ones",  out_ones,  r.ones);
            check("sb_zeros", out_zeros, r.zeros);
            check("sb_diff",  out_diff,  r.diff);
            check("sb_more",  out_more_ones, r.more);
            check("sb_bal",   out_balanced,  r.bal);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  end

  task automatic check_out(input string tag, input res_t e);
    check({tag, "_ones"},  out_ones,  e.ones);
    check({tag, "_zeros"}, out_zeros, e.zeros);
    check({tag, "_diff"},  out_diff,  e.diff);
    check({tag, "_more"},  out_more_ones, e.more);
    check({tag, "_bal"},   out_balanced,  e.bal);
  endtask

  // Wait (bounded) for out_valid; returns edges elapsed and whether
  // in_ready was ever seen high meanwhile.
  task automatic wait_valid(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One word from IDLE through handshake; caller is at posedge+1 in IDLE.
  task automatic run_word(input logic [N-1:0] d, input int hold, input res_t e, input string tag);
    int lat;
    bit saw;
    check({tag, "_idle_ready"}, in_ready, 1);
    in_data = d; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = N'($urandom);
    wait_valid(lat, saw);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_ready_low"}, {31'd0, saw}, 0);
    check_out(tag, e);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_ones"},  out_ones, e.ones);
      check({tag, "_hold_zeros"}, out_zeros, e.zeros);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_after_hs_valid"}, out_valid, 0);
    check({tag, "_after_hs_ready"}, in_ready, 1);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    bit saw;
    res_t r;

    vecs[0] = '{8'b0111_1111, '{7, 1, 6, 1, 0}, 0};
    vecs[1] = '{8'h00,        '{0, 8, 8, 0, 0}, 1};
    vecs[2] = '{8'hA5,        '{4, 4, 0, 0, 1}, 2};
    vecs[3] = '{8'hF0,        '{4, 4, 0, 0, 1}, 5};
    vecs[4] = '{8'hFF,        '{8, 0, 8, 1, 0}, 0};
    vecs[5] = '{8'h01,        '{1, 7, 6, 0, 0}, 1};
    vecs[6] = '{8'h3C,        '{4, 4, 0, 0, 1}, 0};
    vecs[7] = '{8'hE7,        '{6, 2, 4, 1, 0}, 3};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ones",      out_ones, 0);
    check("rst_zeros",     out_zeros, 0);
    check("rst_diff",      out_diff, 0);
    check("rst_more",      out_more_ones, 0);
    check("rst_bal",       out_balanced, 0);
    check("rst_in_ready2", in_ready2, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].data, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back 00 then A5 with out_ready high: 10-cycle spacing.
    acc_cyc.delete();
    out_ready = 1'b1; in_data = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hA5;
    wait_valid(lat, saw);
    check("b2b_first_ready_low", {31'd0, saw}, 0);
    check_out("b2b_first", '{0, 8, 8, 0, 0});
    @(posedge clk); #1;
    check("b2b_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, saw);
    check_out("b2b_second", '{4, 4, 0, 0, 1});
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 10);

    // Flush on the 3rd SCAN cycle of FF.
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_scan_ready", in_ready, 1);
    saw = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    check("flush_scan_no_valid", {31'd0, saw}, 0);

    // Flush coincident with in_valid in IDLE: not accepted.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_ready", in_ready, 1);
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    check("flush_idle_no_valid", {31'd0, saw}, 0);

    // Flush beats a simultaneous output handshake in DONE.
    in_data = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, saw);
    check("flush_done_reached", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_ready", in_ready, 1);

    // Prime nonzero results, then async reset in the middle of SCAN.
    run_word(8'hE7, 0, '{6, 2, 4, 1, 0}, "prime");
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check("arst_scan_ready", in_ready, 1);
    check("arst_scan_valid", out_valid, 0);
    check("arst_scan_ones",  out_ones, 0);
    check("arst_scan_diff",  out_diff, 0);
    check("arst_scan_more",  out_more_ones, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Async reset while in DONE.
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, saw);
    check("arst_done_reached", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_done_valid", out_valid, 0);
    check("arst_done_ready", in_ready, 1);
    check("arst_done_ones",  out_ones, 0);
    check("arst_done_diff",  out_diff, 0);
    check("arst_done_more",  out_more_ones, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_word(8'h01, 0, '{1, 7, 6, 0, 0}, "post_rst");

    // BPC = 2 instance: 11001011 -> 5 ones, latency 4.
    in_data2 = 8'b1100_1011; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bpc2_latency", lat, 4);
    check("bpc2_ones",  out_ones2, 5);
    check("bpc2_zeros", out_zeros2, 3);
    check("bpc2_diff",  out_diff2, 2);
    check("bpc2_more",  out_more_ones2, 1);
    check("bpc2_bal",   out_balanced2, 0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("bpc2_after_hs", in_ready2, 1);

    // Randomized phase against the reference model.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    check("rand_drained", exp_q.size(), 0);
    check("rand_enough_results", {31'd0, n_hs > 20}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bit_balance_seq
`default_nettype wire
